// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing (posx/posy, hsync/vsync, active,
// pixel tick, frame start) from the system clock with an internal pixel divider.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars on test_rgb).
module vga_timing_gen #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned V_ACT  = 480,
  parameter int unsigned V_FP   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] posx,
  output logic [15:0] posy,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [11:0] test_rgb
);

  localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned CW    = 10;
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] HS_END   = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END   = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_BEG   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] HA_END   = CW'(H_SYNC + H_BP + H_ACT);
  localparam logic [CW-1:0] VA_BEG   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] VA_END   = CW'(V_SYNC + V_BP + V_ACT);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          hs_q;
  logic          vs_q;
  logic          act_q;
  logic          tick_q;
  logic          fs_q;

  logic          div_wrap;
  logic [DW-1:0] div_nxt;
  logic          x_wrap;
  logic          y_wrap;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          act_nxt;

  // Next divider/counter values and the decode of the position they lead to
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    div_nxt  = div_wrap ? '0 : div_cnt + DW'(1);
    x_wrap   = (x_q == H_LAST);
    y_wrap   = (y_q == V_LAST);
    x_nxt    = x_wrap ? '0 : x_q + CW'(1);
    y_nxt    = y_q;
    if (x_wrap) begin
      y_nxt = y_wrap ? '0 : y_q + CW'(1);
    end
    hs_nxt  = !(x_nxt < HS_END);
    vs_nxt  = !(y_nxt < VS_END);
    act_nxt = (x_nxt >= HA_BEG) && (x_nxt < HA_END) &&
              (y_nxt >= VA_BEG) && (y_nxt < VA_END);
  end

  // Divider, raster counters and decoded sync/active, all advanced on the pixel tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      act_q   <= 1'b0;
      tick_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else if (en) begin
      div_cnt <= div_nxt;
      tick_q  <= div_wrap;
      fs_q    <= div_wrap && x_wrap && y_wrap;
      if (div_wrap) begin
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        hs_q  <= hs_nxt;
        vs_q  <= vs_nxt;
        act_q <= act_nxt;
      end
    end else begin
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACT / 8;

  logic [2:0]  bar_idx;
  logic [11:0] rgb_nxt;
  logic [11:0] rgb_q;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hfff;
      3'd1:    return 12'hff0;
      3'd2:    return 12'h0ff;
      3'd3:    return 12'h0f0;
      3'd4:    return 12'hf0f;
      3'd5:    return 12'hf00;
      3'd6:    return 12'h00f;
      default: return 12'h000;
    endcase
  endfunction

  // Bar index by threshold compares, avoiding a divider on posx
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_nxt >= CW'(H_SYNC + H_BP + i * BAR_W)) begin
        bar_idx = 3'(i);
      end
    end
    rgb_nxt = act_nxt ? bar_color(bar_idx) : 12'h000;
  end

  // Test colour registered alongside active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 12'h000;
    end else if (en && div_wrap) begin
      rgb_q <= rgb_nxt;
    end
  end

  assign test_rgb = rgb_q;
`else
  assign test_rgb = 12'h000;
`endif

  assign posx        = 16'(x_q);
  assign posy        = 16'(y_q);
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign active      = act_q;
  assign pix_tick    = tick_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances (default DIV=4, default DIV=1, shrunken raster DIV=3)
// checked every cycle against an arithmetic model derived from the enabled-clock count,
// plus a probe table and hand sequences for first tick, en hold, frame period, async reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [15:0] posx_a, posy_a, posx_b, posy_b, posx_c, posy_c;
  logic        hsync_a, vsync_a, active_a, pix_tick_a, frame_start_a;
  logic        hsync_b, vsync_b, active_b, pix_tick_b, frame_start_b;
  logic        hsync_c, vsync_c, active_c, pix_tick_c, frame_start_c;
  logic [11:0] rgb_a, rgb_b, rgb_c;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .posx(posx_a), .posy(posy_a),
    .hsync(hsync_a), .vsync(vsync_a), .active(active_a), .pix_tick(pix_tick_a),
    .frame_start(frame_start_a), .test_rgb(rgb_a)
  );

  vga_timing_gen #(.DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .posx(posx_b), .posy(posy_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b), .pix_tick(pix_tick_b),
    .frame_start(frame_start_b), .test_rgb(rgb_b)
  );

  vga_timing_gen #(
    .DIV(3), .H_SYNC(4), .H_BP(3), .H_ACT(16), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_ACT(8), .V_FP(2)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .posx(posx_c), .posy(posy_c),
    .hsync(hsync_c), .vsync(vsync_c), .active(active_c), .pix_tick(pix_tick_c),
    .frame_start(frame_start_c), .test_rgb(rgb_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    int div, hs, hbp, hact, hfp, vs, vbp, vact, vfp;
  } cfg_t;

  function automatic cfg_t get_cfg(input int k);
    cfg_t c;
    case (k)
      0:       c = '{4, 96, 48, 640, 16, 2, 33, 480, 10};
      1:       c = '{1, 96, 48, 640, 16, 2, 33, 480, 10};
      default: c = '{3, 4, 3, 16, 2, 2, 3, 8, 2};
    endcase
    return c;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_rgb(input longint idx);
    logic [11:0] colours [8];
    colours = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000};
    return colours[idx];
  endfunction
`endif

  // Expected outputs from n = enabled clocks since reset and whether the last edge was enabled
  function automatic logic [48:0] model(input int k, input longint n, input bit last_en);
    cfg_t c;
    longint htot, vtot, pix, x, y, hb, vb;
    bit tick, fs, hs, vs, act;
    logic [11:0] rgb;
    c    = get_cfg(k);
    htot = c.hs + c.hbp + c.hact + c.hfp;
    vtot = c.vs + c.vbp + c.vact + c.vfp;
    pix  = n / c.div;
    x    = pix % htot;
    y    = (pix / htot) % vtot;
    tick = last_en && (n > 0) && ((n % c.div) == 0);
    fs   = tick && (x == 0) && (y == 0);
    hs   = !(x < c.hs);
    vs   = !(y < c.vs);
    hb   = c.hs + c.hbp;
    vb   = c.vs + c.vbp;
    act  = (x >= hb) && (x < hb + c.hact) && (y >= vb) && (y < vb + c.vact);
    rgb  = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (act) begin
      longint idx;
      idx = (x - hb) / (c.hact / 8);
      if (idx > 7) idx = 7;
      rgb = bar_rgb(idx);
    end
`endif
    return {16'(x), 16'(y), hs, vs, act, tick, fs, rgb};
  endfunction

  function automatic logic [48:0] obs(input int k);
    case (k)
      0:       return {posx_a, posy_a, hsync_a, vsync_a, active_a, pix_tick_a, frame_start_a, rgb_a};
      1:       return {posx_b, posy_b, hsync_b, vsync_b, active_b, pix_tick_b, frame_start_b, rgb_b};
      default: return {posx_c, posy_c, hsync_c, vsync_c, active_c, pix_tick_c, frame_start_c, rgb_c};
    endcase
  endfunction

  // Reference state: enabled-clock count and last-edge enable
  longint mn;
  bit     mlast;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn    <= 0;
      mlast <= 1'b0;
    end else begin
      mlast <= en;
      if (en) mn <= mn + 1;
    end
  end

  // Per-cycle scoreboard on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sb_inst%0d", k), obs(k), model(k, mn, mlast));
    end
  end

  typedef struct {
    int x, y;
    bit hs, vs, act;
    logic [11:0] rgb;
  } probe_t;

  // Window/sync boundary probes on the default-size DIV=1 instance
  task automatic b_probes();
    probe_t tbl [12];
    int n;
    logic [11:0] exp_rgb;
    tbl[0]  = '{95,  0,  1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{96,  0,  1'b1, 1'b0, 1'b0, 12'h000};
    tbl[2]  = '{799, 1,  1'b1, 1'b0, 1'b0, 12'h000};
    tbl[3]  = '{0,   2,  1'b0, 1'b1, 1'b0, 12'h000};
    tbl[4]  = '{144, 34, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[5]  = '{143, 35, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[6]  = '{144, 35, 1'b1, 1'b1, 1'b1, 12'hfff};
    tbl[7]  = '{223, 35, 1'b1, 1'b1, 1'b1, 12'hfff};
    tbl[8]  = '{224, 35, 1'b1, 1'b1, 1'b1, 12'hff0};
    tbl[9]  = '{783, 35, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[10] = '{784, 35, 1'b1, 1'b1, 1'b0, 12'h000};
    tbl[11] = '{100, 36, 1'b1, 1'b1, 1'b0, 12'h000};
    for (int i = 0; i < 12; i++) begin
      n = 0;
      while (!(posx_b == 16'(tbl[i].x) && posy_b == 16'(tbl[i].y)) && n < 40000) begin
        @(negedge clk);
        n++;
      end
`ifdef VGA_TEST_PATTERN_EN
      exp_rgb = tbl[i].rgb;
`else
      exp_rgb = 12'h000;
`endif
      check($sformatf("b_reach_%0d", i), {posx_b, posy_b}, {16'(tbl[i].x), 16'(tbl[i].y)});
      check($sformatf("b_hsync_%0d", i), hsync_b, tbl[i].hs);
      check($sformatf("b_vsync_%0d", i), vsync_b, tbl[i].vs);
      check($sformatf("b_active_%0d", i), active_b, tbl[i].act);
      check($sformatf("b_rgb_%0d", i), rgb_b, exp_rgb);
    end
  endtask

  // Line period on the default DIV=4 instance, with a 50-clk enable drop at posx=400
  task automatic a_seq();
    int cnt, t1, n;
    bit seen;
    cnt = 4;
    n = 0;
    do begin @(negedge clk); cnt++; n++; end while (!(pix_tick_a && posx_a == 0) && n < 4000);
    check("a_line0_clks", cnt, 3200);
    check("a_posy_after_wrap", posy_a, 1);
    t1 = cnt;
    n = 0;
    do begin @(negedge clk); cnt++; n++; end while (posx_a != 400 && n < 4000);
    check("a_reach_400", posx_a, 400);
    en = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      cnt++;
      seen |= pix_tick_a;
    end
    check("a_hold_posx", posx_a, 400);
    check("a_hold_tick", seen, 0);
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); cnt++; n++; end while (!pix_tick_a && n < 20);
    check("a_resume_gap", n, 4);
    check("a_resume_posx", posx_a, 401);
    n = 0;
    do begin @(negedge clk); cnt++; n++; end while (!(pix_tick_a && posx_a == 0) && n < 4000);
    check("a_line1_clks", cnt - t1, 3250);
    check("a_posy_line2", posy_a, 2);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_posx", posx_a, 0);
    check("rst_posy", posy_a, 0);
    check("rst_hsync", hsync_a, 0);
    check("rst_vsync", vsync_a, 0);
    check("rst_active", active_a, 0);
    check("rst_tick", pix_tick_a, 0);
    check("rst_fs", frame_start_a, 0);
    check("rst_rgb", rgb_a, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_tick_a && n < 20);
    check("a_first_tick_clks", n, 4);
    check("a_first_tick_posx", posx_a, 1);

    fork
      a_seq();
      b_probes();
    join

    // Frame period on the shrunken instance: 25*15*3 clks
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start_c && n < 3000);
    check("c_fs_found", frame_start_c, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start_c && n < 3000);
    check("c_frame_clks", n, 1125);
    check("c_fs_pos", {posx_c, posy_c}, 0);
    check("c_fs_tick", pix_tick_c, 1);

    // Random enable pattern, covered by the scoreboard
    repeat (6000) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-line
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (posx_a != 500 && n < 4000);
    check("a_reach_500", posx_a, 500);
    @(posedge clk);
    #2;
    check("pre_rst_hsync", hsync_a, 1);
    rst_n = 1'b0;
    #1;
    check("arst_posx_a", posx_a, 0);
    check("arst_posy_a", posy_a, 0);
    check("arst_hsync_a", hsync_a, 0);
    check("arst_vsync_a", vsync_a, 0);
    check("arst_posx_b", posx_b, 0);
    check("arst_hsync_b", hsync_b, 0);
    check("arst_posx_c", posx_c, 0);
    check("arst_posy_c", posy_c, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing: the posx/posy coordinates, hsync/vsync and a pixel tick.
- Drives the screen renderers (game, start and end screens). Those renderers treat posx 144..783 and posy 35..514 as the visible window, so this block produces coordinates in exactly that frame of reference.
- Runs from the 100 MHz system clock. A pixel clock-enable is derived internally by division.

Parameters:
- DIV, 4: system clocks per pixel. Legal range 1..16.
- H_SYNC, 96: hsync pulse width in pixels.
- H_BP, 48: horizontal back porch in pixels.
- H_ACT, 640: horizontal visible pixels.
- H_FP, 16: horizontal front porch in pixels.
- V_SYNC, 2: vsync pulse width in lines.
- V_BP, 33: vertical back porch in lines.
- V_ACT, 480: visible lines.
- V_FP, 10: vertical front porch in lines.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable. Low freezes all counters and outputs.
- posx  output  16  horizontal counter. 0..H_TOT-1, where H_TOT = sum of the H_ parameters = 800.
- posy  output  16  vertical counter. 0..V_TOT-1, where V_TOT = 525.
- hsync  output  1  active-low horizontal sync.
- vsync  output  1  active-low vertical sync.
- active  output  1  high while inside the visible window.
- pix_tick  output  1  one-clk pulse marking each pixel advance.
- frame_start  output  1  one-clk pulse when (posx,posy) wraps to (0,0).
- test_rgb  output  12  test-pattern colour. See Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Divider, posx and posy cleared to 0.
  - pix_tick=0, frame_start=0.
  - hsync=0 and vsync=0, because count 0 lies inside the sync pulse.
  - active=0, test_rgb=0.
- Divider:
  - div_cnt counts 0..DIV-1 on each clk while en=1.
  - pix_tick is registered and high for the single clk in which div_cnt==DIV-1. At that same edge the counters advance.
  - With DIV=1, pix_tick is constantly 1 while en=1.
- Horizontal counter, on each advance:
  - posx==H_TOT-1 → posx=0 and the line advances.
  - Otherwise posx=posx+1.
- Vertical counter, on each line advance:
  - posy==V_TOT-1 → posy=0.
  - Otherwise posy=posy+1.
- Simultaneous wrap: when both counters wrap at the same edge, frame_start=1 for that one clk, aligned with pix_tick.
- Decoded outputs are registered and updated at the same edge as the counters, so they are always consistent with the current posx/posy (zero skew):
  - hsync = !(posx < H_SYNC)
  - vsync = !(posy < V_SYNC)
  - active = (posx >= H_SYNC+H_BP) && (posx < H_SYNC+H_BP+H_ACT) && (posy >= V_SYNC+V_BP) && (posy < V_SYNC+V_BP+V_ACT)
  - With the defaults, active covers posx 144..783 and posy 35..514.
- Widths:
  - Counters are internally 10 bits, zero-extended to 16 at the ports.
  - The wrap comparisons must be exact. No overflow past H_TOT-1 or V_TOT-1 is ever visible.
- en=0:
  - div_cnt, posx, posy and all decoded outputs hold their values.
  - pix_tick and frame_start are forced to 0 on the next clk.
  - Resuming with en=1 continues from the held div_cnt. No pixel is skipped or repeated.
- Reset mid-frame: immediate asynchronous clear. The first pix_tick after release comes DIV clks after rst_n rises while en=1.
- Period and rate:
  - Frame period = H_TOT*V_TOT*DIV clks = 1,680,000 with the defaults.
  - frame_start rate is exactly one per frame.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - test_rgb is registered and aligned with active.
  - Inside the visible window it shows 8 vertical colour bars, each 80 pixels wide, indexed by (posx-144)/80. The bar order is 12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000.
  - Outside the visible window test_rgb=0.
- Not defined: test_rgb is tied to 12'h000 and no bar logic is synthesized.

Test Plan:
- Reset then en=1, DIV=4: first pix_tick at clk 4 after release → posx=1. posx reaches 799 then wraps to 0 exactly 3200 clks per line, and posy increments at the wrap.
- Run one full frame: frame_start pulses once, 1,680,000 clks after the previous pulse. hsync is low for posx 0..95 only. vsync is low for posy 0..1 only.
- Check active: 0 at (143,35) and at (144,34); 1 at (144,35) and at (783,514); 0 at (784,514) and at (144,515).
- Drop en for 50 clks at posx=400: posx stays 400, pix_tick=0 throughout. After en returns, the next advance occurs after the remaining divider count, and the line period equals 3200 clks plus 50.
- Assert rst_n=0 asynchronously mid-line at posx=500, posy=200: outputs clear with no clk edge. hsync=0, vsync=0, posx=0, posy=0.
- With VGA_TEST_PATTERN_EN: posx=144,posy=35 → test_rgb=fff; posx=224 → ff0; posx=783 → 000; posx=100 → 000. Without the macro: test_rgb=0 everywhere.
